// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO and flush kill.
// Define FAST_MULT_EN to use a single-cycle multiplier; division stays iterative.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic             Kill,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH);
`ifdef FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_d;
    logic [2*WIDTH-1:0] p, mul_next, div_next, prod;
    logic [WIDTH-1:0]   m, a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     add_sum, shl, diff;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, dz, is_div;
    logic               accept, op_mul, op_div, a_neg, b_neg, last;
    always_comb begin
        op_mul   = Op[2:1] == 2'b00;
        op_div   = Op[2:1] == 2'b01;
        accept   = Start && !Kill && state == IDLE;
        a_neg    = !Op[0] && BusA[WIDTH-1];
        b_neg    = !Op[0] && BusB[WIDTH-1];
        a_mag    = a_neg ? -BusA : BusA;
        b_mag    = b_neg ? -BusB : BusB;
        last     = cnt == CW'(WIDTH - 1);
        add_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? m : {WIDTH{1'b0}}};
        mul_next = {add_sum, p[WIDTH-1:1]};
        shl      = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff     = shl - {1'b0, m};
        div_next = diff[WIDTH] ? {shl[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        prod     = neg_q ? -p : p;
        quo      = dz ? {WIDTH{1'b1}} : neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem      = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:     state_d = !accept ? IDLE : op_div ? DIV : (op_mul && !FAST) ? MUL : IDLE;
            MUL, DIV: state_d = last ? FIX : state;
            default:  state_d = IDLE;
        endcase
        if (Kill) state_d = IDLE;
    end
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else state <= state_d;
    end
    assign Busy = state != IDLE;
`ifdef FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_mag;
    assign fast_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
    always_ff @(posedge CLK) begin
        if (Reset) begin
            p <= '0;
            m <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            is_div <= 1'b0;
            Hi <= '0;
            Lo <= '0;
            Done <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op_mul || op_div) begin
                        cnt <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dz <= op_div && BusB == '0;
                        is_div <= op_div;
                        m <= op_div ? b_mag : a_mag;
                        p <= {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
                    end
                    if (Op == 3'b100) Hi <= BusA;
                    if (Op == 3'b101) Lo <= BusA;
`ifdef FAST_MULT_EN
                    if (op_mul) begin
                        {Hi, Lo} <= (a_neg ^ b_neg) ? -fast_mag : fast_mag;
                        Done <= 1'b1;
                    end
`endif
                end
                MUL: begin
                    p <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    p <= div_next;
                    cnt <= cnt + 1'b1;
                end
                default: if (!Kill) begin
                    {Hi, Lo} <= is_div ? {rem, quo} : prod;
                    Done <= 1'b1;
                    DivZero <= dz;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (expected HI/LO/flag and Done cycle queued at issue).
module tb_mult_div_unit;
`ifdef FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
    localparam logic [2:0] LONG_OP = FAST ? DIV : MULT;
    logic        CLK = 1'b0, Reset = 1'b1, Start = 1'b0, Kill = 1'b0;
    logic [2:0]  Op = 3'b111;
    logic [31:0] BusA = '0, BusB = '0;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;
    int          cyc = 0, n_checks = 0, n_errors = 0;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;
    exp_t sb[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB), .Kill(Kill),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        logic [63:0] r, q, md;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        r = '0;
        q = '0;
        md = '0;
        if ((op == DIV || op == DIVU) && b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        case (op)
            MULT:  r = sa * sb2;
            MULTU: r = {32'b0, a} * {32'b0, b};
            DIV: begin
                q = sa / sb2;
                md = sa % sb2;
                r = {md[31:0], q[31:0]};
            end
            default: r = {a % b, a / b};
        endcase
        return {1'b0, r};
    endfunction

    always @(negedge CLK) begin
        if (!Reset) begin
            check("divzero_only_with_done", {63'b0, DivZero & ~Done}, 64'd0);
            if (Done) begin
                if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("hi", {32'b0, Hi}, {32'b0, e.hi});
                    check("lo", {32'b0, Lo}, {32'b0, e.lo});
                    check("divzero", {63'b0, DivZero}, {63'b0, e.dz});
                    check("done_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [64:0] r;
        r = model(op, a, b);
        e.dz = r[64];
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.due = cyc + ((FAST && op[2:1] == 2'b00) ? 1 : 33);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
        @(posedge CLK);
        #1;
        Start = 1'b1;
        Op = op;
        BusA = a;
        BusB = b;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Op = 3'b111;
        BusA = $urandom;
        BusB = $urandom;
        if (expect_res) push(op, a, b);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            check("result_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] h0, l0, ra, rb;
        logic [2:0]  rop;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs", {29'b0, Busy, Done, DivZero, Hi}, 64'd0);
        check("reset_lo", {32'b0, Lo}, 64'd0);
        Reset = 1'b0;

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("busy_after_start", {63'b0, Busy}, {63'b0, !FAST});
        drain();
        issue(MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        drain();
        issue(MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
        drain();
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        drain();
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        drain();
        issue(DIVU, 32'd100, 32'd7, 1'b1);
        drain();
        issue(DIVU, 32'd5, 32'd0, 1'b1);
        drain();
        issue(DIV, 32'hFFFF_FFFB, 32'd0, 1'b1);
        drain();
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            issue(rop, ra, rb, 1'b1);
            drain();
        end

        issue(MTHI, 32'h0000_CAFE, 32'hDEAD, 1'b0);
        check("mthi_hi", {32'b0, Hi}, 64'h0000_CAFE);
        check("mthi_busy", {62'b0, Busy, Done}, 64'd0);
        issue(MTLO, 32'h0000_1234, 32'hBEEF, 1'b0);
        check("mtlo_lo", {32'b0, Lo}, 64'h0000_1234);
        check("mtlo_hi_kept", {32'b0, Hi}, 64'h0000_CAFE);
        h0 = Hi;
        l0 = Lo;
        issue(3'b110, 32'h5555_5555, 32'h3, 1'b0);
        @(negedge CLK);
        check("op11x_state", {Hi, Lo}, {h0, l0});
        check("op11x_busy", {62'b0, Busy, Done}, 64'd0);

        issue(LONG_OP, 32'h0000_0123, 32'h0000_0045, 1'b0);
        repeat (9) @(posedge CLK);
        #1;
        Kill = 1'b1;
        Start = 1'b1;
        Op = MTHI;
        BusA = 32'h7777_7777;
        @(posedge CLK);
        #1;
        Kill = 1'b0;
        Start = 1'b0;
        Op = 3'b111;
        @(negedge CLK);
        check("kill_busy", {63'b0, Busy}, 64'd0);
        check("kill_lo", {32'b0, Lo}, 64'h0000_1234);
        check("kill_start_dropped", {32'b0, Hi}, 64'h0000_CAFE);
        repeat (40) @(negedge CLK);
        check("kill_no_write", {Hi, Lo}, {32'h0000_CAFE, 32'h0000_1234});
        issue(DIVU, 32'd1000, 32'd33, 1'b1);
        drain();

        issue(MULTU, 32'd3, 32'd5, 1'b1);
        repeat (5) @(posedge CLK);
        #1;
        Start = 1'b1;
        Op = DIVU;
        BusA = 32'd99;
        BusB = 32'd0;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Op = 3'b111;
        drain();

        issue(LONG_OP, 32'h0BAD_F00D, 32'h0000_0777, 1'b0);
        repeat (19) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_mid_outs", {29'b0, Busy, Done, DivZero, Hi}, 64'd0);
        check("reset_mid_lo", {32'b0, Lo}, 64'd0);
        Reset = 1'b0;
        repeat (40) @(negedge CLK);
        check("reset_mid_quiet", {Hi, Lo}, 64'd0);

        issue(MULTU, 32'd6, 32'd7, 1'b1);
        for (int i = 0; i < 60 && !Done; i++) @(negedge CLK);
        if (!Done) check("b2b_done_timeout", 64'd0, 64'd1);
        else begin
            Start = 1'b1;
            Op = DIVU;
            BusA = 32'd100;
            BusB = 32'd7;
            @(posedge CLK);
            #1;
            Start = 1'b0;
            Op = 3'b111;
            push(DIVU, 32'd100, 32'd7);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
